// File: rtl/i3c_exit_generator_pkg.sv
// Shared definitions for the I3C HDR Exit / HDR Restart pattern generator:
// state encodings, fall counts and the per-state bus drive table.
package i3c_exit_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREP     = 3'd1,
        ST_FALL     = 3'd2,
        ST_RISE     = 3'd3,
        ST_STOP_SCL = 3'd4,
        ST_STOP_SDA = 3'd5,
        ST_RS_SCL   = 3'd6
    } state_t;

    localparam int EXIT_FALLS    = 4;
    localparam int RESTART_FALLS = 2;

    typedef struct packed {
        logic scl;
        logic sda;
        logic oena;
    } bus_t;

    localparam bus_t BUS_IDLE     = '{scl: 1'b1, sda: 1'b1, oena: 1'b0};
    localparam bus_t BUS_PREP     = '{scl: 1'b0, sda: 1'b1, oena: 1'b1};
    localparam bus_t BUS_FALL     = '{scl: 1'b0, sda: 1'b0, oena: 1'b1};
    localparam bus_t BUS_RISE     = '{scl: 1'b0, sda: 1'b1, oena: 1'b1};
    localparam bus_t BUS_STOP_SCL = '{scl: 1'b1, sda: 1'b0, oena: 1'b1};
    localparam bus_t BUS_STOP_SDA = '{scl: 1'b1, sda: 1'b1, oena: 1'b1};
    localparam bus_t BUS_RS_SCL   = '{scl: 1'b1, sda: 1'b1, oena: 1'b1};

    function automatic bus_t bus_for(state_t s);
        bus_t b;
        case (s)
            ST_PREP:     b = BUS_PREP;
            ST_FALL:     b = BUS_FALL;
            ST_RISE:     b = BUS_RISE;
            ST_STOP_SCL: b = BUS_STOP_SCL;
            ST_STOP_SDA: b = BUS_STOP_SDA;
            ST_RS_SCL:   b = BUS_RS_SCL;
            default:     b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i3c_exit_generator_phase_timer.sv
// Phase timer: counts PHASE_CLKS cycles per bus phase; `last` flags the final
// cycle of the phase. `restart` zeroes the count on any state change.
module i3c_exit_phase_timer #(
    parameter int PHASE_CLKS = 4
) (
    input  logic clk,
    input  logic RSTn,
    input  logic restart,
    output logic last
);

    localparam int W = $clog2(PHASE_CLKS + 1);
    localparam logic [W-1:0] LAST_CNT = W'(PHASE_CLKS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (restart || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/i3c_exit_generator.sv
// Controller-side I3C HDR Exit / HDR Restart pin pattern generator.
// Optional SDA readback check: define I3C_EXIT_SDA_CHECK_EN.
module i3c_exit_generator
    import i3c_exit_generator_pkg::*;
#(
    parameter logic [2:0] ENA_HDR    = 3'b000,
    parameter int         PHASE_CLKS = 4
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       req_exit,
    input  logic       req_restart,
    input  logic       pin_SDA_in,
    output logic       busy,
    output logic       done,
    output logic       pin_SCL_out,
    output logic       pin_SCL_oena,
    output logic       pin_SDA_out,
    output logic       pin_SDA_oena,
    output logic       err_sda,
    output logic [2:0] dbg_state
);

    // fall_cnt is 2 bits wide, so the fourth fall of an exit wraps it to 0.
    localparam logic [1:0] EXIT_DONE_CNT    = 2'(EXIT_FALLS);
    localparam logic [1:0] RESTART_DONE_CNT = 2'(RESTART_FALLS);

    state_t     state, state_nx;
    logic       mode_rs, mode_rs_nx;
    logic [1:0] fall_cnt, fall_cnt_nx;
    logic       accept;
    logic       done_nx;
    logic       phase_last;
    bus_t       bus_nx;

    i3c_exit_phase_timer #(
        .PHASE_CLKS(PHASE_CLKS)
    ) u_phase_timer (
        .clk    (clk),
        .RSTn   (RSTn),
        .restart((state == ST_IDLE) || (state_nx != state)),
        .last   (phase_last)
    );

    always_comb begin
        state_nx    = state;
        mode_rs_nx  = mode_rs;
        fall_cnt_nx = fall_cnt;
        accept      = 1'b0;
        done_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_exit) begin
                    accept      = 1'b1;
                    mode_rs_nx  = 1'b0;
                    fall_cnt_nx = 2'd0;
                    state_nx    = ST_PREP;
                end else if (req_restart && (ENA_HDR != 3'b000)) begin
                    accept      = 1'b1;
                    mode_rs_nx  = 1'b1;
                    fall_cnt_nx = 2'd0;
                    state_nx    = ST_PREP;
                end
            end
            ST_PREP: begin
                if (phase_last) begin
                    state_nx    = ST_FALL;
                    fall_cnt_nx = fall_cnt + 2'd1;
                end
            end
            ST_FALL: begin
                if (phase_last) begin
                    if (!mode_rs && (fall_cnt == EXIT_DONE_CNT)) begin
                        state_nx = ST_STOP_SCL;
                    end else begin
                        state_nx = ST_RISE;
                    end
                end
            end
            ST_RISE: begin
                if (phase_last) begin
                    if (mode_rs && (fall_cnt == RESTART_DONE_CNT)) begin
                        state_nx = ST_RS_SCL;
                    end else begin
                        state_nx    = ST_FALL;
                        fall_cnt_nx = fall_cnt + 2'd1;
                    end
                end
            end
            ST_STOP_SCL: begin
                if (phase_last) begin
                    state_nx = ST_STOP_SDA;
                end
            end
            ST_STOP_SDA, ST_RS_SCL: begin
                if (phase_last) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus_nx = bus_for(state_nx);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_IDLE;
            mode_rs      <= 1'b0;
            fall_cnt     <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pin_SCL_out  <= 1'b1;
            pin_SDA_out  <= 1'b1;
            pin_SCL_oena <= 1'b0;
            pin_SDA_oena <= 1'b0;
        end else begin
            state        <= state_nx;
            mode_rs      <= mode_rs_nx;
            fall_cnt     <= fall_cnt_nx;
            busy         <= (state_nx != ST_IDLE);
            done         <= done_nx;
            pin_SCL_out  <= bus_nx.scl;
            pin_SDA_out  <= bus_nx.sda;
            pin_SCL_oena <= bus_nx.oena;
            pin_SDA_oena <= bus_nx.oena;
        end
    end

`ifdef I3C_EXIT_SDA_CHECK_EN
    // Readback is judged on the settled last cycle of each phase only.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            err_sda <= 1'b0;
        end else if (accept) begin
            err_sda <= 1'b0;
        end else if ((state != ST_IDLE) && phase_last && pin_SDA_oena &&
                     (pin_SDA_in != pin_SDA_out)) begin
            err_sda <= 1'b1;
        end
    end
`else
    logic unused_sda_in;
    logic unused_accept;
    assign unused_sda_in = pin_SDA_in;
    assign unused_accept = accept;
    assign err_sda       = 1'b0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_i3c_exit_generator.sv
// Bench for i3c_exit_generator: two instances (restart disabled / enabled),
// a cycle-level pattern model checked every cycle, plus directed count checks.
module tb_i3c_exit_generator;

    localparam int P = 4;

    logic clk = 1'b0;
    logic rstn;
    logic req_exit;
    logic req_restart;
    logic force_sda;

    logic busy0, done0, scl0, scl_oe0, sda0, sda_oe0, err0, sda_in0;
    logic busy1, done1, scl1, scl_oe1, sda1, sda_oe1, err1, sda_in1;
    logic [2:0] st0, st1;

    always #5 clk = ~clk;

    assign sda_in0 = force_sda ? 1'b1 : sda0;
    assign sda_in1 = force_sda ? 1'b1 : sda1;

    i3c_exit_generator #(.ENA_HDR(3'b000), .PHASE_CLKS(P)) u_dut0 (
        .clk(clk), .RSTn(rstn), .req_exit(req_exit), .req_restart(req_restart),
        .pin_SDA_in(sda_in0), .busy(busy0), .done(done0),
        .pin_SCL_out(scl0), .pin_SCL_oena(scl_oe0),
        .pin_SDA_out(sda0), .pin_SDA_oena(sda_oe0),
        .err_sda(err0), .dbg_state(st0)
    );

    i3c_exit_generator #(.ENA_HDR(3'b001), .PHASE_CLKS(P)) u_dut1 (
        .clk(clk), .RSTn(rstn), .req_exit(req_exit), .req_restart(req_restart),
        .pin_SDA_in(sda_in1), .busy(busy1), .done(done1),
        .pin_SCL_out(scl1), .pin_SCL_oena(scl_oe1),
        .pin_SDA_out(sda1), .pin_SDA_oena(sda_oe1),
        .err_sda(err1), .dbg_state(st1)
    );

    // {busy, done, scl, scl_oena, sda, sda_oena, err}
    logic [6:0] act_v [2];
    assign act_v[0] = {busy0, done0, scl0, scl_oe0, sda0, sda_oe0, err0};
    assign act_v[1] = {busy1, done1, scl1, scl_oe1, sda1, sda_oe1, err1};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit ena [2] = '{1'b0, 1'b1};
    bit m_act [2];
    bit m_rs  [2];
    int m_k   [2];
    bit m_err [2];

    function automatic int pat_len(input bit rs);
        return (rs ? 6 : 10) * P;
    endfunction

    function automatic logic scl_of(input bit rs, input int ph);
        return rs ? (ph == 5) : (ph >= 8);
    endfunction

    function automatic logic sda_of(input bit rs, input int ph);
        if (rs) return (ph % 2 == 0) || (ph == 5);
        return (ph == 9) || ((ph < 8) && (ph % 2 == 0));
    endfunction

    function automatic logic [6:0] exp_vec(input int i);
        int ph;
        if (!m_act[i]) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_err[i]};
        if (m_k[i] == pat_len(m_rs[i])) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, m_err[i]};
        ph = m_k[i] / P;
        return {1'b1, 1'b0, scl_of(m_rs[i], ph), 1'b1, sda_of(m_rs[i], ph), 1'b1, m_err[i]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;
                m_err[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && (m_k[i] == pat_len(m_rs[i]))) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
`ifdef I3C_EXIT_SDA_CHECK_EN
                    if ((m_k[i] % P == P - 1) && force_sda &&
                        !sda_of(m_rs[i], m_k[i] / P))
                        m_err[i] = 1'b1;
`endif
                    m_k[i]++;
                end
                if (!m_act[i]) begin
                    if (req_exit || (req_restart && ena[i])) begin
                        m_act[i] = 1'b1;
                        m_rs[i]  = !req_exit;
                        m_k[i]   = 0;
                        m_err[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("cycle_out0", int'(act_v[0]), int'(exp_vec(0)));
            chk("cycle_out1", int'(act_v[1]), int'(exp_vec(1)));
        end
    end

    // ---------------- event monitor for directed checks ----------------
    int cyc = 0;
    int n_busy [2], n_fall [2], n_done [2], n_oena [2];
    int n_scl_up_sda0 [2], n_scl_up_sda1 [2], n_sda_up_scl1 [2];
    int first_busy [2], done_at [2];
    logic prev_scl [2], prev_sda [2];

    always @(negedge clk) begin
        logic [6:0] v;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            v = act_v[i];
            if (v[6]) begin
                if (n_busy[i] == 0) first_busy[i] = cyc;
                n_busy[i]++;
            end
            if (v[5]) begin
                n_done[i]++;
                done_at[i] = cyc;
            end
            if (v[3] || v[1]) n_oena[i]++;
            if (prev_sda[i] && !v[2] && !v[4] && v[1]) n_fall[i]++;
            if (!prev_scl[i] && v[4] && !v[2]) n_scl_up_sda0[i]++;
            if (!prev_scl[i] && v[4] && v[2]) n_scl_up_sda1[i]++;
            if (!prev_sda[i] && v[2] && v[4]) n_sda_up_scl1[i]++;
            prev_scl[i] = v[4];
            prev_sda[i] = v[2];
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            n_busy[i] = 0; n_fall[i] = 0; n_done[i] = 0; n_oena[i] = 0;
            n_scl_up_sda0[i] = 0; n_scl_up_sda1[i] = 0; n_sda_up_scl1[i] = 0;
            first_busy[i] = 0; done_at[i] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn        = 1'b0;
        req_exit    = 1'b0;
        req_restart = 1'b0;
        force_sda   = 1'b0;
        clear_mon();
        tick(3);

        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_scl0", scl0, 1);
        chk("rst_sda0", sda0, 1);
        chk("rst_oena0", scl_oe0 | sda_oe0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_state0", st0, int'(i3c_exit_generator_pkg::ST_IDLE));
        chk("rst_state1", st1, int'(i3c_exit_generator_pkg::ST_IDLE));
        rstn = 1'b1;
        tick(2);

        // 1: exit pattern on both instances
        clear_mon();
        req_exit = 1'b1;
        tick(1);
        req_exit = 1'b0;
        tick(50);
        for (int i = 0; i < 2; i++) begin
            chk("t1_busy_cycles", n_busy[i], 40);
            chk("t1_sda_falls", n_fall[i], 4);
            chk("t1_scl_up_sda0", n_scl_up_sda0[i], 1);
            chk("t1_sda_up_scl1", n_sda_up_scl1[i], 1);
            chk("t1_done_count", n_done[i], 1);
            chk("t1_done_offset", done_at[i] - first_busy[i], 40);
        end
        chk("t1_oena_after", scl_oe0 | sda_oe0 | scl_oe1 | sda_oe1, 0);

        // 2: restart pulse; only the HDR-enabled instance responds
        clear_mon();
        req_restart = 1'b1;
        tick(1);
        req_restart = 1'b0;
        tick(40);
        chk("t2_busy_cycles", n_busy[1], 24);
        chk("t2_sda_falls", n_fall[1], 2);
        chk("t2_scl_up_sda1", n_scl_up_sda1[1], 1);
        chk("t2_done_count", n_done[1], 1);
        chk("t2_ignored_oena", n_oena[0], 0);

        // 3: restart held on the HDR-disabled instance, then exit honoured
        clear_mon();
        req_restart = 1'b1;
        tick(100);
        chk("t3_no_oena", n_oena[0], 0);
        chk("t3_no_done", n_done[0], 0);
        clear_mon();
        req_exit = 1'b1;
        tick(1);
        req_exit    = 1'b0;
        req_restart = 1'b0;
        tick(60);
        chk("t3_exit_falls", n_fall[0], 4);
        chk("t3_exit_done", n_done[0], 1);

        // 4: simultaneous requests pick exit; mid-pattern restart ignored
        clear_mon();
        req_exit    = 1'b1;
        req_restart = 1'b1;
        tick(1);
        req_exit    = 1'b0;
        req_restart = 1'b0;
        tick(10);
        req_restart = 1'b1;
        tick(1);
        req_restart = 1'b0;
        tick(50);
        chk("t4_falls", n_fall[1], 4);
        chk("t4_busy_cycles", n_busy[1], 40);
        chk("t4_done_count", n_done[1], 1);

        // 5: async reset in the middle of the third FALL
        clear_mon();
        req_exit = 1'b1;
        tick(1);
        req_exit = 1'b0;
        tick(21);
        chk("t5_in_fall3_falls", n_fall[0], 3);
        chk("t5_in_fall3_sda", sda0, 0);
        rstn = 1'b0;
        #1;
        chk("t5_rst_oena0", scl_oe0 | sda_oe0, 0);
        chk("t5_rst_oena1", scl_oe1 | sda_oe1, 0);
        chk("t5_rst_busy", busy0 | busy1, 0);
        tick(1);
        rstn = 1'b1;
        tick(1);
        chk("t5_idle0", st0, int'(i3c_exit_generator_pkg::ST_IDLE));
        chk("t5_idle1", st1, int'(i3c_exit_generator_pkg::ST_IDLE));

        // 6: SDA readback stuck high during an exit
        clear_mon();
        force_sda = 1'b1;
        req_exit  = 1'b1;
        tick(1);
        req_exit = 1'b0;
        tick(50);
        force_sda = 1'b0;
`ifdef I3C_EXIT_SDA_CHECK_EN
        chk("t6_err_set", err0, 1);
        tick(5);
        chk("t6_err_sticky", err0, 1);
        req_exit = 1'b1;
        tick(1);
        req_exit = 1'b0;
        tick(1);
        chk("t6_err_cleared", err0, 0);
`else
        chk("t6_err_tied0", err0 | err1, 0);
        req_exit = 1'b1;
        tick(1);
        req_exit = 1'b0;
        tick(1);
`endif
        tick(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
